// File: rtl/pattern_stream_gen_pkg.sv
// Shared definitions for the pattern stream generator: state encoding, default widths, default pattern.
package pattern_stream_gen_pkg;

  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned GAP_W_DEF = 4;

  localparam logic [PAT_W_DEF-1:0] DEF_PATTERN = 4'b1101;

  // One-hot, matching the detector state style
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_GAP   = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

endpackage

// File: rtl/pattern_stream_gen_if.sv
// Control/stream bundle between a job requester/sink (master) and the generator (slave).
interface pattern_stream_gen_if
  import pattern_stream_gen_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) ();

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap_len;
  logic             ready;
  logic             dout;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;

  modport master (
    output start, pattern, repeat_n, gap_len, ready,
    input  dout, valid, busy, done, sent_cnt
  );

  modport slave (
    input  start, pattern, repeat_n, gap_len, ready,
    output dout, valid, busy, done, sent_cnt
  );

endinterface

// File: rtl/pattern_stream_gen_shift_reg.sv
// Pattern holder: loads on request and rotates left on each transferred bit, so after
// PAT_W rotations it is back at the original pattern for the next repetition.
module pattern_stream_gen_shift_reg
  import pattern_stream_gen_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_data,
  input  logic             i_rot,
  output logic             o_msb,
  output logic             o_next_msb
);

  logic [PAT_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_rot) begin
      r_q <= {r_q[PAT_W-2:0], r_q[PAT_W-1]};
    end
  end

  assign o_msb      = r_q[PAT_W-1];
  assign o_next_msb = r_q[PAT_W-2];

endmodule

// File: rtl/pattern_stream_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first repeat_n times with
// gap_len idle cycles between repetitions, under valid/ready flow control.
module pattern_stream_gen
  import pattern_stream_gen_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pattern_stream_gen_if.slave  bus
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  state_t           r_state;
  logic             r_dout;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] r_rep;
  logic [GAP_W-1:0] r_gap_len;
  logic [GAP_W-1:0] r_gap;
  logic [IDX_W-1:0] r_idx;

  logic             w_accept;
  logic             w_load;
  logic             w_xfer;
  logic             w_msb;
  logic             w_next_msb;
  logic [CNT_W-1:0] w_sent_inc;

  assign w_accept   = (r_state == ST_IDLE) && bus.start;
  assign w_load     = w_accept && (bus.repeat_n != '0);
  assign w_xfer     = (r_state == ST_SHIFT) && bus.ready;
  assign w_sent_inc = r_sent + CNT_W'(1);

  pattern_stream_gen_shift_reg #(.PAT_W(PAT_W)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_data     (bus.pattern),
    .i_rot      (w_xfer),
    .o_msb      (w_msb),
    .o_next_msb (w_next_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_dout    <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sent    <= '0;
      r_rep     <= '0;
      r_gap_len <= '0;
      r_gap     <= '0;
      r_idx     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rep     <= bus.repeat_n;
            r_gap_len <= bus.gap_len;
            r_sent    <= '0;
            r_idx     <= IDX_MAX;
            if (bus.repeat_n == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
              r_valid <= 1'b1;
              r_dout  <= bus.pattern[PAT_W-1];
            end
          end
        end
        ST_SHIFT: begin
          // Without ready everything holds, so no bit is dropped or repeated
          if (bus.ready) begin
            if (r_idx == '0) begin
              r_sent <= w_sent_inc;
              if (w_sent_inc == r_rep) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_dout  <= 1'b0;
              end else if (r_gap_len == '0) begin
                r_idx  <= IDX_MAX;
                r_dout <= w_next_msb;
              end else begin
                r_state <= ST_GAP;
                r_gap   <= r_gap_len - GAP_W'(1);
                r_valid <= 1'b0;
                r_dout  <= 1'b0;
              end
            end else begin
              r_idx  <= r_idx - IDX_W'(1);
              r_dout <= w_next_msb;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            r_state <= ST_SHIFT;
            r_idx   <= IDX_MAX;
            r_valid <= 1'b1;
            r_dout  <= w_msb;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_dout  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout     = r_dout;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sent_cnt = r_sent;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Directed bench for pattern_stream_gen: per-cycle expected {busy,done,valid,dout} strings.
module tb_pattern_stream_gen;
  import pattern_stream_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pattern_stream_gen_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

  pattern_stream_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs();
    return {bus.busy, bus.done, bus.valid, bus.dout};
  endfunction

  // '1'/'0' valid bit, '-' busy idle gap, 'D' done pulse, '_' idle not busy
  function automatic logic [3:0] sym(input byte ch);
    case (ch)
      "1":     return 4'b1011;
      "0":     return 4'b1010;
      "-":     return 4'b1000;
      "D":     return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  // mode 1: ready low for cycles 2..4; mode 2: a second start with other settings at cycle 3
  task automatic run_job(input string tag, input logic [3:0] pat, input logic [7:0] rep,
                         input logic [3:0] gap, input int mode, input string exp);
    @(posedge clk); #1;
    bus.pattern  = pat;
    bus.repeat_n = rep;
    bus.gap_len  = gap;
    bus.ready    = 1'b1;
    bus.start    = 1'b1;
    for (int c = 1; c <= exp.len(); c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.start = 1'b0;
      check_eq($sformatf("%s_c%0d", tag, c), 32'(obs()), 32'(sym(exp[c-1])));
      bus.ready = !(mode == 1 && c >= 2 && c <= 4);
      if (mode == 2 && c == 3) begin
        bus.start    = 1'b1;
        bus.pattern  = 4'b0010;
        bus.repeat_n = 8'd5;
        bus.gap_len  = 4'd3;
      end
      if (mode == 2 && c == 4) bus.start = 1'b0;
    end
  endtask

  initial begin
    int seen;
    bus.start    = 1'b0;
    bus.pattern  = '0;
    bus.repeat_n = '0;
    bus.gap_len  = '0;
    bus.ready    = 1'b1;

    #12;
    check_eq("rst_outputs", 32'(obs()), 32'(4'b0000));
    check_eq("rst_sent", 32'(bus.sent_cnt), 32'd0);
    rst = 1'b1;

    run_job("t2", DEF_PATTERN, 8'd3, 4'd0, 0, "110111011101D_");
    check_eq("t2_sent", 32'(bus.sent_cnt), 32'd3);

    run_job("t3", DEF_PATTERN, 8'd3, 4'd2, 0, "1101--1101--1101D_");
    check_eq("t3_sent", 32'(bus.sent_cnt), 32'd3);

    run_job("t4", DEF_PATTERN, 8'd3, 4'd0, 1, "111110111011101D_");
    check_eq("t4_sent", 32'(bus.sent_cnt), 32'd3);

    run_job("t5", DEF_PATTERN, 8'd0, 4'd0, 0, "D_");
    check_eq("t5_sent", 32'(bus.sent_cnt), 32'd0);

    run_job("t6", DEF_PATTERN, 8'd3, 4'd0, 2, "110111011101D_");
    check_eq("t6_sent", 32'(bus.sent_cnt), 32'd3);

    run_job("t7", 4'b0110, 8'd2, 4'd1, 0, "0110-0110D_");
    check_eq("t7_sent", 32'(bus.sent_cnt), 32'd2);

    // Asynchronous reset during bit 2 of repetition 3
    @(posedge clk); #1;
    bus.pattern  = DEF_PATTERN;
    bus.repeat_n = 8'd3;
    bus.gap_len  = 4'd0;
    bus.ready    = 1'b1;
    bus.start    = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.start = 1'b0;
    end
    check_eq("t1_pre_obs", 32'(obs()), 32'(4'b1011));
    check_eq("t1_pre_sent", 32'(bus.sent_cnt), 32'd2);
    #2 rst = 1'b0;
    #1;
    check_eq("t1_async_obs", 32'(obs()), 32'(4'b0000));
    check_eq("t1_async_sent", 32'(bus.sent_cnt), 32'd0);
    check_eq("t1_async_state", 32'(dut.r_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.valid || bus.busy) seen++;
    end
    check_eq("t1_quiet", 32'(seen), 32'd0);

    run_job("t8", DEF_PATTERN, 8'd1, 4'd0, 0, "1101D_");
    check_eq("t8_sent", 32'(bus.sent_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
